// File: rtl/cpu_host_sequencer.sv
// cpu_host_sequencer
//   Feeds operand pairs to a small CPU and collects its results. The CPU is
//   held in reset while idle. After a pair is accepted, reset stays high for
//   RESET_CYCLES cycles. Reset is then released, and the CPU runs until it
//   raises halt. Its output and carry are captured and offered on a
//   valid/ready result port.
//
// Optional feature (macro HOST_TIMEOUT_EN):
//   When defined, a run that lasts TIMEOUT_CYCLES cycles without a halt is
//   aborted. The CPU output is captured and res_timeout is flagged. When not
//   defined, RUN waits forever, no counter logic is built, and res_timeout is
//   tied low.
//
// Ports:
//   Clock, Reset          rising-edge clock, asynchronous active-high reset
//   op_valid/op_ready     operand handshake; op_a/op_b are the operands
//   cpu_A, cpu_B          operands driven to the CPU; held from one acceptance
//                         until the next
//   cpu_reset             CPU reset; low only while in RUN
//   cpu_halt              CPU halt input, sampled only in RUN
//   cpu_output, cpu_cout  CPU result and carry out
//   res_valid/res_ready   result handshake; res_data, res_cout and
//                         res_timeout are held while res_valid is high
//   busy                  high in any state other than IDLE
//   run_count             number of results consumed; wraps from 255 to 0
module cpu_host_sequencer #(
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic [7:0] cpu_A,
  output logic [7:0] cpu_B,
  output logic       cpu_reset,
  input  logic       cpu_halt,
  input  logic [7:0] cpu_output,
  input  logic       cpu_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_cout,
  output logic       res_timeout,
  output logic       busy,
  output logic [7:0] run_count
);

  // Reject illegal parameter values at elaboration time.
  if (RESET_CYCLES < 1 || RESET_CYCLES > 15) begin : g_bad_reset_cycles
    $error("cpu_host_sequencer: RESET_CYCLES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
    $error("cpu_host_sequencer: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LOAD_LAST = 4'(RESET_CYCLES - 1);

  state_t     state_q, state_d;
  logic       ready_en_q, ready_en_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [3:0] load_cnt_q, load_cnt_d;
  logic [7:0] data_q, data_d;
  logic       cout_q, cout_d;
  logic [7:0] run_count_q, run_count_d;

`ifdef HOST_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] run_cnt_q, run_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // ready_en_q is cleared by Reset and set on the first clock edge after
  // Reset falls. This keeps op_ready low throughout reset, even though the
  // state is already IDLE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      ready_en_q  <= 1'b0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      load_cnt_q  <= 4'h0;
      data_q      <= 8'h00;
      cout_q      <= 1'b0;
      run_count_q <= 8'h00;
`ifdef HOST_TIMEOUT_EN
      run_cnt_q   <= 8'h00;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_en_q  <= ready_en_d;
      a_q         <= a_d;
      b_q         <= b_d;
      load_cnt_q  <= load_cnt_d;
      data_q      <= data_d;
      cout_q      <= cout_d;
      run_count_q <= run_count_d;
`ifdef HOST_TIMEOUT_EN
      run_cnt_q   <= run_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_en_d  = 1'b1;
    a_d         = a_q;
    b_d         = b_q;
    load_cnt_d  = load_cnt_q;
    data_d      = data_q;
    cout_d      = cout_q;
    run_count_d = run_count_q;
`ifdef HOST_TIMEOUT_EN
    run_cnt_d   = run_cnt_q;
    timeout_d   = timeout_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (op_valid && ready_en_q) begin
          a_d        = op_a;
          b_d        = op_b;
          load_cnt_d = 4'h0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          state_d = RUN;
`ifdef HOST_TIMEOUT_EN
          run_cnt_d = 8'h00;
`endif
        end else begin
          load_cnt_d = load_cnt_q + 4'h1;
        end
      end
      RUN: begin
        // When halt and expiry fall on the same cycle, halt wins, so the
        // result is reported as a normal completion.
        if (cpu_halt) begin
          data_d  = cpu_output;
          cout_d  = cpu_cout;
          state_d = DONE;
`ifdef HOST_TIMEOUT_EN
          timeout_d = 1'b0;
        end else if (run_cnt_q == TIMEOUT_LAST) begin
          data_d    = cpu_output;
          cout_d    = cpu_cout;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          run_cnt_d = run_cnt_q + 8'h01;
`endif
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          run_count_d = run_count_q + 8'h01;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_ready  = (state_q == IDLE) && ready_en_q;
  assign cpu_reset = (state_q != RUN);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign cpu_A     = a_q;
  assign cpu_B     = b_q;
  assign res_data  = data_q;
  assign res_cout  = cout_q;
  assign run_count = run_count_q;
`ifdef HOST_TIMEOUT_EN
  assign res_timeout = timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_host_sequencer.sv
// Directed bench for cpu_host_sequencer.
// The bench drives inputs and samples outputs on the falling edge of Clock.
module tb_cpu_host_sequencer;

  localparam int RC = 2;
  localparam int TC = 8;

  logic       Clock, Reset;
  logic       op_valid, op_ready;
  logic [7:0] op_a, op_b, cpu_A, cpu_B;
  logic       cpu_reset, cpu_halt, cpu_cout;
  logic [7:0] cpu_output;
  logic       res_valid, res_ready, res_cout, res_timeout, busy;
  logic [7:0] res_data, run_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_count = 8'h00;
  logic [7:0] cur_a, cur_b;

  cpu_host_sequencer #(.RESET_CYCLES(RC), .TIMEOUT_CYCLES(TC)) dut (
    .Clock(Clock), .Reset(Reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .cpu_A(cpu_A), .cpu_B(cpu_B), .cpu_reset(cpu_reset),
    .cpu_halt(cpu_halt), .cpu_output(cpu_output), .cpu_cout(cpu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_cout(res_cout), .res_timeout(res_timeout), .busy(busy),
    .run_count(run_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Offer a pair and check the LOAD phase: cpu_reset must stay high for
  // exactly RC cycles. On return, the bench is at the first RUN cycle.
  // load_halt drives cpu_halt high throughout LOAD.
  task automatic accept_and_load(input logic [7:0] a, input logic [7:0] b, input logic load_halt);
    int w;
    int lc;
    w = 0;
    while (op_ready !== 1'b1 && w < 20) begin
      @(negedge Clock);
      w++;
    end
    n_checks++;
    if (op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: op_ready=%b required 1", op_ready);
    end
    op_a = a; op_b = b; op_valid = 1'b1;
    cur_a = a; cur_b = b;
    @(negedge Clock);
    op_valid = 1'b0;
    op_a = 8'hFF; op_b = 8'hFF;
    n_checks++;
    if (busy !== 1'b1 || op_ready !== 1'b0 || cpu_A !== a || cpu_B !== b) begin
      n_fail++;
      $display("FAIL accept_latch: busy=%b op_ready=%b A=%h B=%h required 1 0 %h %h",
               busy, op_ready, cpu_A, cpu_B, a, b);
    end
    lc = 0;
    while (cpu_reset === 1'b1 && lc < 20) begin
      cpu_halt = load_halt; cpu_output = 8'hEE; cpu_cout = 1'b1;
      n_checks++;
      if (res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL load_no_capture: res_valid=%b required 0", res_valid);
      end
      lc++;
      @(negedge Clock);
    end
    cpu_halt = 1'b0;
    n_checks++;
    if (lc != RC) begin
      n_fail++;
      $display("FAIL load_cycles: cpu_reset high %0d cycles required %0d", lc, RC);
    end
  endtask

  // Start at RUN cycle 1. Halt on RUN cycle h with the given result, then
  // check the captured result one cycle later.
  task automatic run_and_halt(input int h, input logic [7:0] out, input logic co);
    for (int i = 1; i < h; i++) begin
      cpu_output = 8'h3C;
      n_checks++;
      if (res_valid !== 1'b0 || cpu_reset !== 1'b0 || cpu_A !== cur_a || cpu_B !== cur_b) begin
        n_fail++;
        $display("FAIL run_wait: valid=%b cpu_reset=%b A=%h B=%h required 0 0 %h %h",
                 res_valid, cpu_reset, cpu_A, cpu_B, cur_a, cur_b);
      end
      @(negedge Clock);
    end
    cpu_halt = 1'b1; cpu_output = out; cpu_cout = co;
    @(negedge Clock);
    cpu_halt = 1'b0; cpu_output = ~out; cpu_cout = ~co;
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== out || res_cout !== co || res_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL result: valid=%b data=%h cout=%b to=%b required 1 %h %b 0",
               res_valid, res_data, res_cout, res_timeout, out, co);
    end
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(negedge Clock);
    res_ready = 1'b0;
    exp_count = exp_count + 8'h01;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1 || run_count !== exp_count) begin
      n_fail++;
      $display("FAIL handshake_%s: valid=%b busy=%b ready=%b count=%h required 0 0 1 %h",
               tag, res_valid, busy, op_ready, run_count, exp_count);
    end
    $display("txn %s: A=%h B=%h run_count=%h", tag, cur_a, cur_b, run_count);
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (cpu_reset !== 1'b1 || op_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 ||
        res_data !== 8'h00 || res_cout !== 1'b0 || res_timeout !== 1'b0 ||
        cpu_A !== 8'h00 || cpu_B !== 8'h00 || run_count !== 8'h00) begin
      n_fail++;
      $display("FAIL %s: rst=%b rdy=%b val=%b busy=%b data=%h cout=%b to=%b A=%h B=%h cnt=%h required reset values",
               tag, cpu_reset, op_ready, res_valid, busy, res_data, res_cout, res_timeout,
               cpu_A, cpu_B, run_count);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check_reset_values("reset_values");
    @(negedge Clock);
    Reset = 1'b0;
    exp_count = 8'h00;
    #1;
    n_checks++;
    if (op_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: op_ready=%b required 0", op_ready);
    end
    @(negedge Clock);
    n_checks++;
    if (op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: op_ready=%b required 1", op_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    // res_ready while nothing is pending must be ignored.
    res_ready = 1'b1;
    @(negedge Clock);
    res_ready = 1'b0;
    n_checks++;
    if (run_count !== 8'h00 || busy !== 1'b0 || op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_res_ready: count=%h busy=%b ready=%b required 00 0 1", run_count, busy, op_ready);
    end
  endtask

  task automatic test_basic();
    accept_and_load(8'h05, 8'h03, 1'b0);
    run_and_halt(4, 8'h08, 1'b0);
    handshake("basic");
  endtask

  task automatic test_backpressure();
    accept_and_load(8'h10, 8'h20, 1'b0);
    run_and_halt(2, 8'h30, 1'b1);
    for (int i = 0; i < 10; i++) begin
      op_valid = i[0]; op_a = 8'hAA; op_b = 8'hBB;
      @(negedge Clock);
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 8'h30 || res_cout !== 1'b1 || op_ready !== 1'b0 ||
          cpu_A !== 8'h10 || cpu_B !== 8'h20) begin
        n_fail++;
        $display("FAIL backpressure: valid=%b data=%h cout=%b ready=%b A=%h B=%h required 1 30 1 0 10 20",
                 res_valid, res_data, res_cout, op_ready, cpu_A, cpu_B);
      end
    end
    op_valid = 1'b0;
    handshake("backpressure");
  endtask

  task automatic test_early_halt();
    accept_and_load(8'h07, 8'h09, 1'b1);
    run_and_halt(1, 8'h42, 1'b0);
    handshake("early_halt");
  endtask

`ifdef HOST_TIMEOUT_EN
  task automatic test_timeout();
    accept_and_load(8'h11, 8'h22, 1'b0);
    for (int i = 1; i <= TC; i++) begin
      cpu_output = 8'h77; cpu_cout = 1'b1;
      n_checks++;
      if (res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_early: valid=%b at RUN cycle %0d required 0", res_valid, i);
      end
      @(negedge Clock);
    end
    cpu_output = 8'h00; cpu_cout = 1'b0;
    n_checks++;
    if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_data !== 8'h77 || res_cout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: valid=%b to=%b data=%h cout=%b required 1 1 77 1",
               res_valid, res_timeout, res_data, res_cout);
    end
    handshake("timeout");
    // Halt on the expiry cycle wins; run_and_halt checks res_timeout=0.
    accept_and_load(8'h33, 8'h44, 1'b0);
    run_and_halt(TC, 8'h99, 1'b1);
    handshake("halt_at_expiry");
  endtask
`endif

  task automatic test_reset_mid_run();
    accept_and_load(8'h01, 8'h02, 1'b0);
    @(negedge Clock);
    do_reset();
    accept_and_load(8'h21, 8'h12, 1'b0);
    run_and_halt(3, 8'h33, 1'b0);
    handshake("after_reset");
  endtask

  task automatic test_wrap();
    logic [7:0] a, b;
    @(negedge Clock);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a = 8'(i * 7 + 1);
      b = 8'(255 - i);
      accept_and_load(a, b, 1'b0);
      run_and_halt(1 + (i % 3), a ^ b, i[0]);
      handshake("wrap");
    end
    n_checks++;
    if (run_count !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_final: run_count=%h required 00", run_count);
    end
  endtask

  initial begin
    Reset = 1'b1; op_valid = 1'b0; op_a = 8'h00; op_b = 8'h00;
    cpu_halt = 1'b0; cpu_output = 8'h00; cpu_cout = 1'b0; res_ready = 1'b0;
    cur_a = 8'h00; cur_b = 8'h00;
    @(negedge Clock);
    test_reset();
    test_basic();
    test_backpressure();
    test_early_halt();
`ifdef HOST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_run();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_host_sequencer.md
CPU_HOST_SEQUENCER -- requirements
Module: cpu_host_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2, the number of cycles cpu_reset is held per run (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of RUN cycles before abort (legal range 1..255; used only with HOST_TIMEOUT_EN).
REQ-003 SHALL use one clock; reset is asynchronous and active-high, with ports named Clock and Reset.
REQ-004 Clock  in  1  system clock; all state updates on the rising edge.
REQ-005 Reset  in  1  asynchronous, active-high block reset.
REQ-006 op_valid  in  1  operand pair offered; op_ready  out  1  sequencer accepts the pair.
REQ-007 op_a, op_b  in  8 each  operands for the next CPU run.
REQ-008 cpu_A, cpu_B  out  8 each  operands driven to the CPU A/B inputs.
REQ-009 cpu_reset  out  1  drives the CPU Reset input.
REQ-010 cpu_halt  in  1  CPU Halt, synchronous to Clock.
REQ-011 cpu_output  in  8  CPU Output; cpu_cout  in  1  CPU carry out.
REQ-012 res_valid  out  1  result available; res_ready  in  1  result consumed.
REQ-013 res_data  out  8  captured result; res_cout  out  1  captured carry; res_timeout  out  1  run aborted.
REQ-014 busy  out  1  high in any state other than IDLE; run_count  out  8  completed-result counter.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, RUN and DONE.
REQ-016 IDLE behaviour: op_ready=1 and cpu_reset=1; when op_valid&op_ready, latch op_a/op_b into cpu_A/cpu_B and enter LOAD on the next cycle.
REQ-017 LOAD behaviour: cpu_reset=1 for exactly RESET_CYCLES cycles, then enter RUN; op_ready=0.
REQ-018 RUN behaviour: cpu_reset=0; the first cycle in which cpu_halt=1 captures cpu_output->res_data and cpu_cout->res_cout, clears res_timeout, and enters DONE.
REQ-019 cpu_halt SHALL be ignored in IDLE, LOAD and DONE.
REQ-020 DONE behaviour: res_valid=1 and res_data/res_cout/res_timeout are held stable until res_ready=1.
REQ-021 On the res_valid&res_ready cycle, the next state is IDLE, res_valid falls the following cycle, and run_count increments, wrapping 255->0.
REQ-022 cpu_A/cpu_B SHALL remain constant from acceptance until the next acceptance.
REQ-023 Latency from acceptance to cpu_reset deassertion SHALL be RESET_CYCLES+1 cycles.
REQ-024 Latency from a halt sampled in RUN to res_valid high SHALL be 1 cycle.
REQ-025 res_ready while res_valid=0 SHALL have no effect.
REQ-026 op_valid outside IDLE SHALL be ignored, with no acceptance and no queuing.

Reset
REQ-027 While Reset=1, the sequencer SHALL be in IDLE.
REQ-028 While Reset=1: cpu_reset=1, op_ready=0, and res_valid, busy, res_data, res_cout, res_timeout, cpu_A, cpu_B and run_count are 0.
REQ-029 op_ready SHALL rise on the first clock edge after Reset falls.
REQ-030 Reset during LOAD, RUN or DONE SHALL discard the run and any pending result, and SHALL leave run_count at 0.

Configuration
REQ-031 Macro HOST_TIMEOUT_EN defined: a RUN-cycle counter is cleared on RUN entry.
REQ-032 Macro HOST_TIMEOUT_EN defined: if TIMEOUT_CYCLES RUN cycles elapse without halt, the sequencer captures cpu_output/cpu_cout, sets res_timeout=1 and enters DONE.
REQ-033 Macro HOST_TIMEOUT_EN defined: a halt on the same cycle as expiry takes priority, giving res_timeout=0.
REQ-034 Macro HOST_TIMEOUT_EN undefined: RUN waits indefinitely for halt, res_timeout is constant 0, and no counter logic exists.

Verification
REQ-035 Basic run: RESET_CYCLES=2; send op_a=0x05, op_b=0x03; CPU model halts 4 cycles after cpu_reset falls with Output 0x08, cout 0 -> cpu_reset high exactly 2 LOAD cycles; res_valid=1 one cycle after halt; res_data=0x08; run_count=1 after the handshake.
REQ-036 Backpressure: hold res_ready=0 for 10 cycles after res_valid -> res_data stable; op_ready=0; op_valid pulses ignored; release -> IDLE the next cycle.
REQ-037 Timeout: HOST_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, no halt -> res_valid after 8 RUN cycles with res_timeout=1; halt on the 8th cycle -> res_timeout=0.
REQ-038 Reset mid-run: assert Reset during RUN -> all outputs immediately at reset values; the next run completes normally with run_count=1.
REQ-039 Wrap: complete 256 runs -> run_count returns to 0x00; cpu_A/cpu_B match each accepted pair throughout its run.
REQ-040 Early halt: cpu_halt held high during LOAD, released, then reasserted on RUN cycle 1 -> no capture in LOAD; capture on RUN cycle 1.
